// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester/response channels and the shared-ALU connection
// of alu_arbiter into one interface.
//   req0_* / req1_* : operation request channels (valid/ready, ctrl, a, b)
//   rsp0_* / rsp1_* : result channels (valid/ready, data, compare flag)
//   alu_*           : connection to the shared combinational ALU
//   busy            : arbiter is not idle
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters and the shared ALU)
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
   parameter int DATA_BIT_WIDTH = 32,
   parameter int CTRL_BIT_WIDTH = 5
);
   logic                      req0_valid;
   logic                      req0_ready;
   logic [CTRL_BIT_WIDTH-1:0] req0_ctrl;
   logic [DATA_BIT_WIDTH-1:0] req0_a;
   logic [DATA_BIT_WIDTH-1:0] req0_b;
   logic                      rsp0_valid;
   logic                      rsp0_ready;
   logic [DATA_BIT_WIDTH-1:0] rsp0_data;
   logic                      rsp0_cmp;

   logic                      req1_valid;
   logic                      req1_ready;
   logic [CTRL_BIT_WIDTH-1:0] req1_ctrl;
   logic [DATA_BIT_WIDTH-1:0] req1_a;
   logic [DATA_BIT_WIDTH-1:0] req1_b;
   logic                      rsp1_valid;
   logic                      rsp1_ready;
   logic [DATA_BIT_WIDTH-1:0] rsp1_data;
   logic                      rsp1_cmp;

   logic [CTRL_BIT_WIDTH-1:0] alu_ctrl;
   logic [DATA_BIT_WIDTH-1:0] alu_in1;
   logic [DATA_BIT_WIDTH-1:0] alu_in2;
   logic [DATA_BIT_WIDTH-1:0] alu_data;
   logic                      alu_cmp;

   logic                      busy;

   modport slave (
      input  req0_valid, req0_ctrl, req0_a, req0_b, rsp0_ready,
      input  req1_valid, req1_ctrl, req1_a, req1_b, rsp1_ready,
      input  alu_data, alu_cmp,
      output req0_ready, rsp0_valid, rsp0_data, rsp0_cmp,
      output req1_ready, rsp1_valid, rsp1_data, rsp1_cmp,
      output alu_ctrl, alu_in1, alu_in2, busy
   );

   modport master (
      output req0_valid, req0_ctrl, req0_a, req0_b, rsp0_ready,
      output req1_valid, req1_ctrl, req1_a, req1_b, rsp1_ready,
      output alu_data, alu_cmp,
      input  req0_ready, rsp0_valid, rsp0_data, rsp0_cmp,
      input  req1_ready, rsp1_valid, rsp1_data, rsp1_cmp,
      input  alu_ctrl, alu_in1, alu_in2, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: IDLE grants a requester (round-robin on ties), EXEC gives
// the ALU one cycle with the latched operands, RESP holds the result for the
// owner until it is taken.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_arbiter_if.slave (request/response channels, ALU, busy)
// Opcodes are never decoded here; they pass to the ALU untouched.
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DATA_BIT_WIDTH = 32,
   parameter int CTRL_BIT_WIDTH = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic                      owner_q, owner_d;
   logic                      lastOwner_q, lastOwner_d;
   logic [CTRL_BIT_WIDTH-1:0] opCtrl_q, opCtrl_d;
   logic [DATA_BIT_WIDTH-1:0] opA_q, opA_d;
   logic [DATA_BIT_WIDTH-1:0] opB_q, opB_d;
   logic [DATA_BIT_WIDTH-1:0] result_q, result_d;
   logic                      resultCmp_q, resultCmp_d;

   logic grant0;
   logic grant1;
   logic ownerRspReady;
   logic readyEnable;

   // Requester 1 wins when it is alone, or on a tie when requester 0 was
   // served last (lastOwner_q == 0). Requester 0 takes every other case.
   assign grant1 = bus.req1_valid & (~bus.req0_valid | ~lastOwner_q);
   assign grant0 = bus.req0_valid & ~grant1;

   assign ownerRspReady = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

   // Ready is combinational from valid, so it must also be masked by reset:
   // the state register alone would read IDLE while reset is held.
   assign readyEnable = (state_q == IDLE) & reset_n;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         lastOwner_q <= 1'b1;
         opCtrl_q    <= '0;
         opA_q       <= '0;
         opB_q       <= '0;
         result_q    <= '0;
         resultCmp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lastOwner_q <= lastOwner_d;
         opCtrl_q    <= opCtrl_d;
         opA_q       <= opA_d;
         opB_q       <= opB_d;
         result_q    <= result_d;
         resultCmp_q <= resultCmp_d;
      end
   end

   // Next-state logic: accept in IDLE, sample the ALU at the end of EXEC,
   // release in RESP once the owner takes the result.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lastOwner_d = lastOwner_q;
      opCtrl_d    = opCtrl_q;
      opA_d       = opA_q;
      opB_d       = opB_q;
      result_d    = result_q;
      resultCmp_d = resultCmp_q;

      case (state_q)
         IDLE: begin
            if (grant0 | grant1) begin
               owner_d  = grant1;
               opCtrl_d = grant1 ? bus.req1_ctrl : bus.req0_ctrl;
               opA_d    = grant1 ? bus.req1_a    : bus.req0_a;
               opB_d    = grant1 ? bus.req1_b    : bus.req0_b;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            result_d    = bus.alu_data;
            resultCmp_d = bus.alu_cmp;
            state_d     = RESP;
         end
         RESP: begin
            if (ownerRspReady) begin
               lastOwner_d = owner_q;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req0_ready = readyEnable & grant0;
   assign bus.req1_ready = readyEnable & grant1;

   assign bus.rsp0_valid = (state_q == RESP) & ~owner_q;
   assign bus.rsp1_valid = (state_q == RESP) &  owner_q;

   // The non-owner's result channel always reads zero.
   assign bus.rsp0_data  = owner_q ? '0 : result_q;
   assign bus.rsp1_data  = owner_q ? result_q : '0;
   assign bus.rsp0_cmp   = ~owner_q & resultCmp_q;
   assign bus.rsp1_cmp   =  owner_q & resultCmp_q;

   assign bus.alu_ctrl   = opCtrl_q;
   assign bus.alu_in1    = opA_q;
   assign bus.alu_in2    = opB_q;

   assign bus.busy       = (state_q != IDLE);

endmodule
